dcache_port_arb: RTL and testbench

//   Shares the single dcache request port between three requesters: LSQ loads, LSQ

---
 rtl/dcache_port_arb.sv | 146 ++++++++++++++
 tb/tb_dcache_port_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arb.sv
// Arbitrates LSQ loads, committed stores and an aux reader onto the single dcache port, and routes
// in-order read responses back through an epoch-tagged FIFO. Optional store anti-starvation: DCACHE_ARB_STARVE_EN.
module dcache_port_arb #(
  parameter int DEPTH        = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  output logic        ld_ready,
  input  logic [3:0]  ld_op,
  input  logic [31:0] ld_addr,
  input  logic [4:0]  ld_lsqid,
  input  logic        st_req,
  output logic        st_ready,
  input  logic [3:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic        ax_req,
  output logic        ax_ready,
  input  logic [31:0] ax_addr,
  output logic        dc_req,
  output logic [3:0]  dc_op,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  output logic [4:0]  dc_lsqid,
  input  logic        dcache_ready,
  input  logic        dcache_valid,
  input  logic        dcache_error,
  input  logic [31:0] dcache_rdata,
  input  logic        flush,
  output logic        ld_rsp_valid,
  output logic        ld_rsp_error,
  output logic [4:0]  ld_rsp_lsqid,
  output logic [31:0] ld_rsp_rdata,
  output logic        ax_rsp_valid,
  output logic        ax_rsp_error,
  output logic [31:0] ax_rsp_rdata,
  output logic        arb_err
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dcache_port_arb: DEPTH must be a power of 2 and >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("dcache_port_arb: STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {G_NONE, G_LD, G_ST, G_AX} grant_e;

  typedef struct packed {
    logic       ax;
    logic [4:0] lsqid;
    logic       epoch;
  } tag_t;

  tag_t        fifo_mem [DEPTH];
  tag_t        head;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        epoch;
  logic        empty, pop, push, has_space, promote;
  grant_e      grant;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign pop       = dcache_valid & ~empty;
  // Space is judged after this cycle's pop so a full FIFO can pop and push together.
  assign has_space = (count - (AW+1)'(pop)) < (AW+1)'(DEPTH);
  assign head      = fifo_mem[rd_ptr[AW-1:0]];

`ifdef DCACHE_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  assign promote = (starve_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      starve_cnt <= '0;
    else if (!st_req || st_ready) starve_cnt <= '0;
    else if (!promote)            starve_cnt <= starve_cnt + CW'(1);
  end
`else
  assign promote = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    grant = G_NONE;
    if (promote && st_req)                   grant = G_ST;
    else if (ld_req && !flush && has_space)  grant = G_LD;
    else if (st_req)                         grant = G_ST;
    else if (ax_req && has_space)            grant = G_AX;
    if (rst) grant = G_NONE;
  end

  assign ld_ready = (grant == G_LD) & dcache_ready;
  assign st_ready = (grant == G_ST) & dcache_ready;
  assign ax_ready = (grant == G_AX) & dcache_ready;
  assign dc_req   = (grant != G_NONE);
  assign dc_wdata = st_wdata;
  assign dc_lsqid = (grant == G_LD) ? ld_lsqid : 5'd0;
  assign push     = ld_ready | ax_ready;

  always_comb begin
    dc_op   = 4'b0010;
    dc_addr = ax_addr;
    case (grant)
      G_LD:    begin dc_op = ld_op; dc_addr = ld_addr; end
      G_ST:    begin dc_op = st_op; dc_addr = st_addr; end
      default: ;
    endcase
  end

  assign ld_rsp_valid = pop & ~head.ax & (head.epoch == epoch) & ~rst;
  assign ld_rsp_error = dcache_error;
  assign ld_rsp_lsqid = head.lsqid;
  assign ld_rsp_rdata = dcache_rdata;
  assign ax_rsp_valid = pop & head.ax & ~rst;
  assign ax_rsp_error = dcache_error;
  assign ax_rsp_rdata = dcache_rdata;

  // NOTE: the tag storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= '{ax: (grant == G_AX), lsqid: dc_lsqid, epoch: epoch};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      epoch   <= 1'b0;
      arb_err <= 1'b0;
    end else begin
      if (push)                  wr_ptr  <= wr_ptr + (AW+1)'(1);
      if (pop)                   rd_ptr  <= rd_ptr + (AW+1)'(1);
      if (flush)                 epoch   <= ~epoch;
      if (dcache_valid && empty) arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_port_arb.sv
// Self-checking bench for dcache_port_arb: directed scenarios plus randomized traffic against a
// queue-based reference model. Honours DCACHE_ARB_STARVE_EN when defined.
module tb_dcache_port_arb;

  localparam int DEPTH        = 8;
  localparam int STARVE_LIMIT = 16;

  logic        clk, rst;
  logic        ld_req, ld_ready, st_req, st_ready, ax_req, ax_ready;
  logic [3:0]  ld_op, st_op, dc_op;
  logic [31:0] ld_addr, st_addr, st_wdata, ax_addr, dc_addr, dc_wdata, dcache_rdata;
  logic [4:0]  ld_lsqid, dc_lsqid, ld_rsp_lsqid;
  logic        dc_req, dcache_ready, dcache_valid, dcache_error, flush;
  logic        ld_rsp_valid, ld_rsp_error, ax_rsp_valid, ax_rsp_error, arb_err;
  logic [31:0] ld_rsp_rdata, ax_rsp_rdata;

  dcache_port_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_ready(ld_ready), .ld_op(ld_op), .ld_addr(ld_addr), .ld_lsqid(ld_lsqid),
    .st_req(st_req), .st_ready(st_ready), .st_op(st_op), .st_addr(st_addr), .st_wdata(st_wdata),
    .ax_req(ax_req), .ax_ready(ax_ready), .ax_addr(ax_addr),
    .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_lsqid(dc_lsqid),
    .dcache_ready(dcache_ready), .dcache_valid(dcache_valid), .dcache_error(dcache_error),
    .dcache_rdata(dcache_rdata), .flush(flush),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_error(ld_rsp_error), .ld_rsp_lsqid(ld_rsp_lsqid),
    .ld_rsp_rdata(ld_rsp_rdata), .ax_rsp_valid(ax_rsp_valid), .ax_rsp_error(ax_rsp_error),
    .ax_rsp_rdata(ax_rsp_rdata), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: outstanding reads as a queue of {source, lsqid, epoch}.
  typedef struct { bit ax; bit [4:0] lsqid; bit ep; } ent_t;
  ent_t q[$];
  bit   ep_cur, err_m;
  int   starve_m;
  int   g_m;  // 0 none, 1 load, 2 store, 3 aux
  bit   e_ld_rdy, e_st_rdy, e_ax_rdy, e_dc_req, e_ld_rsp, e_ax_rsp;
  bit [4:0]  e_rsp_lsqid;
  bit [31:0] e_addr;

  function automatic void model_reset();
    q.delete();
    ep_cur = 0; err_m = 0; starve_m = 0;
  endfunction

  function automatic void model_eval();
    bit pop_m, space, promote;
    pop_m   = dcache_valid && q.size() > 0;
    space   = (q.size() - (pop_m ? 1 : 0)) < DEPTH;
    promote = 0;
`ifdef DCACHE_ARB_STARVE_EN
    promote = (starve_m >= STARVE_LIMIT);
`endif
    if (rst)                            g_m = 0;
    else if (promote && st_req)         g_m = 2;
    else if (ld_req && !flush && space) g_m = 1;
    else if (st_req)                    g_m = 2;
    else if (ax_req && space)           g_m = 3;
    else                                g_m = 0;
    e_dc_req = (g_m != 0);
    e_ld_rdy = (g_m == 1) && dcache_ready;
    e_st_rdy = (g_m == 2) && dcache_ready;
    e_ax_rdy = (g_m == 3) && dcache_ready;
    e_addr   = (g_m == 1) ? ld_addr : (g_m == 2) ? st_addr : ax_addr;
    e_ld_rsp = 0; e_ax_rsp = 0; e_rsp_lsqid = 0;
    if (pop_m && !rst) begin
      e_ax_rsp    = q[0].ax;
      e_ld_rsp    = !q[0].ax && (q[0].ep == ep_cur);
      e_rsp_lsqid = q[0].lsqid;
    end
  endfunction

  function automatic void model_update();
    model_eval();
    if (rst) begin
      model_reset();
      return;
    end
    if (dcache_valid && q.size() == 0) err_m = 1;
    if (dcache_valid && q.size() > 0) void'(q.pop_front());
    if (e_ld_rdy) q.push_back('{ax: 1'b0, lsqid: ld_lsqid, ep: ep_cur});
    if (e_ax_rdy) q.push_back('{ax: 1'b1, lsqid: 5'd0, ep: ep_cur});
    if (flush) ep_cur = ~ep_cur;
    if (!st_req || e_st_rdy) starve_m = 0;
    else if (starve_m < STARVE_LIMIT) starve_m++;
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ld_req = 0; st_req = 0; ax_req = 0; flush = 0; dcache_valid = 0; dcache_ready = 1;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 3 * DEPTH && q.size() > 0; i++) begin
      dcache_valid = 1;
      dcache_rdata = $urandom;
      tick();
    end
    dcache_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; model_reset();
    ld_req = 1; st_req = 1; ax_req = 1; dcache_ready = 1; dcache_valid = 1; flush = 0;
    ld_op = 4'b0011; st_op = 4'b1011; ld_addr = 32'h100; st_addr = 32'h200; ax_addr = 32'h300;
    st_wdata = 32'h5; ld_lsqid = 0; dcache_error = 0; dcache_rdata = 0;
    settle();
    if ({ld_ready, st_ready, ax_ready, dc_req} !== 4'b0) begin
      mismatched++; $display("FAIL reset_ready got=%b want=0000", {ld_ready, st_ready, ax_ready, dc_req});
    end
    compared++;
    if ({ld_rsp_valid, ax_rsp_valid, arb_err} !== 3'b0) begin
      mismatched++; $display("FAIL reset_rsp got=%b want=000", {ld_rsp_valid, ax_rsp_valid, arb_err});
    end
    compared++;
    tick();
    rst = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_priority();
    ld_req = 1; st_req = 1; ax_req = 1; ld_lsqid = 5'd1;
    settle();
    if ({ld_ready, st_ready, ax_ready} !== 3'b100 || dc_addr !== ld_addr) begin
      mismatched++; $display("FAIL prio_ld rdy=%b addr=%h want=100 %h", {ld_ready, st_ready, ax_ready}, dc_addr, ld_addr);
    end
    compared++;
    tick();
    ld_req = 0;
    settle();
    if ({ld_ready, st_ready, ax_ready} !== 3'b010 || dc_addr !== st_addr || dc_op !== st_op) begin
      mismatched++; $display("FAIL prio_st rdy=%b addr=%h op=%h", {ld_ready, st_ready, ax_ready}, dc_addr, dc_op);
    end
    compared++;
    tick();
    st_req = 0;
    settle();
    if ({ld_ready, st_ready, ax_ready} !== 3'b001 || dc_op !== 4'b0010 || dc_lsqid !== 5'd0) begin
      mismatched++; $display("FAIL prio_ax rdy=%b op=%h lsqid=%0d", {ld_ready, st_ready, ax_ready}, dc_op, dc_lsqid);
    end
    compared++;
    tick();
    drain();
  endtask

  task automatic test_full();
    ld_req = 1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_lsqid = 5'(i);
      settle();
      if (ld_ready !== 1'b1) begin
        mismatched++; $display("FAIL full_fill%0d ld_ready=%b want=1", i, ld_ready);
      end
      compared++;
      tick();
    end
    ld_lsqid = 5'd20;
    settle();
    if (ld_ready !== 1'b0) begin
      mismatched++; $display("FAIL full_block ld_ready=%b want=0", ld_ready);
    end
    compared++;
    tick();
    dcache_valid = 1;
    settle();
    if (ld_ready !== 1'b1 || ld_rsp_valid !== 1'b1 || ld_rsp_lsqid !== 5'd0) begin
      mismatched++; $display("FAIL full_pushpop rdy=%b rsp=%b lsqid=%0d want=1 1 0", ld_ready, ld_rsp_valid, ld_rsp_lsqid);
    end
    compared++;
    tick();
    dcache_valid = 0;
    settle();
    if (ld_ready !== 1'b0) begin
      mismatched++; $display("FAIL full_still ld_ready=%b want=0", ld_ready);
    end
    compared++;
    tick();
    drain();
  endtask

  task automatic test_flush();
    bit [2:0] want_v;
    ld_req = 1;
    ld_lsqid = 5'd3; tick();
    ld_lsqid = 5'd7; tick();
    flush = 1; ld_lsqid = 5'd8;
    settle();
    if (ld_ready !== 1'b0) begin
      mismatched++; $display("FAIL flush_ineligible ld_ready=%b want=0", ld_ready);
    end
    compared++;
    tick();
    flush = 0; ld_lsqid = 5'd9;
    tick();
    ld_req = 0;
    want_v = 3'b100;
    for (int i = 0; i < 3; i++) begin
      dcache_valid = 1; dcache_rdata = 32'h50 + i;
      settle();
      if (ld_rsp_valid !== want_v[i] || (want_v[i] && ld_rsp_lsqid !== 5'd9)) begin
        mismatched++; $display("FAIL flush_rsp%0d valid=%b lsqid=%0d want=%b 9", i, ld_rsp_valid, ld_rsp_lsqid, want_v[i]);
      end
      compared++;
      tick();
    end
    dcache_valid = 0;
    // A response landing in the flush cycle still belongs to the pre-flush epoch.
    ld_req = 1; ld_lsqid = 5'd4; tick();
    ld_req = 0; flush = 1; dcache_valid = 1;
    settle();
    if (ld_rsp_valid !== 1'b1 || ld_rsp_lsqid !== 5'd4) begin
      mismatched++; $display("FAIL flush_same_cycle valid=%b lsqid=%0d want=1 4", ld_rsp_valid, ld_rsp_lsqid);
    end
    compared++;
    tick();
    drain();
  endtask

  task automatic test_interleave();
    bit [31:0] rd [3];
    rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC;
    ld_req = 1; ld_lsqid = 5'd2; tick();
    ld_req = 0; ax_req = 1; tick();
    ax_req = 0; ld_req = 1; ld_lsqid = 5'd5; tick();
    ld_req = 0;
    for (int i = 0; i < 3; i++) begin
      dcache_valid = 1; dcache_rdata = rd[i];
      settle();
      if (i == 1) begin
        if (ax_rsp_valid !== 1'b1 || ld_rsp_valid !== 1'b0 || ax_rsp_rdata !== 32'hB) begin
          mismatched++; $display("FAIL ilv_ax ax=%b ld=%b data=%h want=1 0 b", ax_rsp_valid, ld_rsp_valid, ax_rsp_rdata);
        end
      end else begin
        if (ld_rsp_valid !== 1'b1 || ax_rsp_valid !== 1'b0 || ld_rsp_rdata !== rd[i] ||
            ld_rsp_lsqid !== ((i == 0) ? 5'd2 : 5'd5)) begin
          mismatched++; $display("FAIL ilv_ld%0d ld=%b ax=%b lsqid=%0d data=%h", i, ld_rsp_valid, ax_rsp_valid, ld_rsp_lsqid, ld_rsp_rdata);
        end
      end
      compared++;
      tick();
    end
    dcache_valid = 0;
  endtask

  task automatic test_starve();
    int first_st, want_first;
    first_st = -1;
`ifdef DCACHE_ARB_STARVE_EN
    want_first = STARVE_LIMIT + 1;
`else
    want_first = -1;
`endif
    ld_req = 1; st_req = 1;
    for (int c = 1; c <= STARVE_LIMIT + 8; c++) begin
      ld_lsqid = 5'(c);
      dcache_valid = (q.size() > 0);
      settle();
      if (st_ready !== e_st_rdy || ld_ready !== e_ld_rdy) begin
        mismatched++; $display("FAIL starve_c%0d st=%b ld=%b want=%b %b", c, st_ready, ld_ready, e_st_rdy, e_ld_rdy);
      end
      compared++;
      if (st_ready === 1'b1 && first_st < 0) first_st = c;
      tick();
    end
    if (first_st != want_first) begin
      mismatched++; $display("FAIL starve_first got=%0d want=%0d", first_st, want_first);
    end
    compared++;
    drain();
  endtask

  task automatic test_err_reset();
    idle_inputs();
    dcache_valid = 1;
    settle();
    if ({ld_rsp_valid, ax_rsp_valid} !== 2'b00) begin
      mismatched++; $display("FAIL err_no_rsp got=%b want=00", {ld_rsp_valid, ax_rsp_valid});
    end
    compared++;
    tick();
    dcache_valid = 0;
    settle();
    if (arb_err !== 1'b1) begin
      mismatched++; $display("FAIL err_sticky arb_err=%b want=1", arb_err);
    end
    compared++;
    ld_req = 1;
    for (int i = 0; i < 4; i++) begin
      ld_lsqid = 5'(10 + i);
      tick();
    end
    dcache_valid = 1; st_req = 1;
    @(negedge clk);
    rst = 1;
    #1;
    if ({ld_ready, st_ready, dc_req, ld_rsp_valid, arb_err} !== 5'b0) begin
      mismatched++; $display("FAIL rst_mid got=%b want=00000", {ld_ready, st_ready, dc_req, ld_rsp_valid, arb_err});
    end
    compared++;
    tick();
    rst = 0;
    idle_inputs();
    dcache_valid = 1;
    settle();
    if (ld_rsp_valid !== 1'b0 || ax_rsp_valid !== 1'b0) begin
      mismatched++; $display("FAIL rst_empty rsp=%b%b want=00", ld_rsp_valid, ax_rsp_valid);
    end
    compared++;
    tick();
    dcache_valid = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ld_req = $urandom_range(0, 1); st_req = ($urandom_range(0, 3) == 0); ax_req = $urandom_range(0, 1);
      ld_addr = $urandom; st_addr = $urandom; ax_addr = $urandom; st_wdata = $urandom;
      ld_op = 4'($urandom_range(0, 7)); st_op = 4'($urandom_range(8, 15)); ld_lsqid = 5'($urandom);
      dcache_ready = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 15) == 0);
      dcache_valid = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 63) == 0);
      dcache_rdata = $urandom; dcache_error = $urandom_range(0, 1);
      settle();
      if ({ld_ready, st_ready, ax_ready, dc_req} !== {e_ld_rdy, e_st_rdy, e_ax_rdy, e_dc_req} ||
          (e_dc_req && dc_addr !== e_addr) || (e_dc_req && dc_wdata !== st_wdata)) begin
        mismatched++; $display("FAIL rnd_arb%0d got=%b addr=%h want=%b addr=%h", c,
          {ld_ready, st_ready, ax_ready, dc_req}, dc_addr, {e_ld_rdy, e_st_rdy, e_ax_rdy, e_dc_req}, e_addr);
      end
      compared++;
      if (ld_rsp_valid !== e_ld_rsp || ax_rsp_valid !== e_ax_rsp || arb_err !== err_m ||
          (e_ld_rsp && (ld_rsp_lsqid !== e_rsp_lsqid || ld_rsp_rdata !== dcache_rdata || ld_rsp_error !== dcache_error)) ||
          (e_ax_rsp && (ax_rsp_rdata !== dcache_rdata || ax_rsp_error !== dcache_error))) begin
        mismatched++; $display("FAIL rnd_rsp%0d ld=%b ax=%b lsqid=%0d err=%b want=%b %b %0d %b", c,
          ld_rsp_valid, ax_rsp_valid, ld_rsp_lsqid, arb_err, e_ld_rsp, e_ax_rsp, e_rsp_lsqid, err_m);
      end
      compared++;
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_full();
    test_flush();
    test_interleave();
    test_starve();
    test_err_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
